// File: rtl/sr_ff_driver.sv
// sr_ff_driver: queued excitation driver for an SR flip-flop.
// Each command names a target q. The driver applies the legal one-cycle s/r
// excitation for that target, then checks the returned q. It can keep
// monitoring q for a programmable number of hold cycles. Any mismatch pulses
// err, bumps a saturating counter and resyncs the internal q model.
// s and r are never asserted together.
module sr_ff_driver #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_bit,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              q_fb,
  output logic              s,
  output logic              r,
  output logic              q_model,
  output logic              busy,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, HOLD} state_t;

  // Saturating increment: the mismatch count sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Each FIFO entry is {target bit, hold count}.
  logic [HOLD_W:0]     mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                full, empty, push, pop;
  logic [HOLD_W:0]     head;

  state_t              state_q, state_d;
  logic                tgt_q, tgt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                q_model_q, q_model_d;
  logic                s_q, s_d, r_q, r_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                mismatch;

  // The pointers carry one extra wrap bit. Equal pointers mean empty.
  // Pointers that differ only in the wrap bit mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign cmd_ready = !full;
  assign busy      = (state_q != IDLE) || !empty;
  assign s         = s_q;
  assign r         = r_q;
  assign q_model   = q_model_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  // FIFO storage is written on accepted commands; reset discards it via the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_bit, cmd_hold};
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Next-state, excitation and mismatch logic.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    hold_cnt_d = hold_cnt_q;
    q_model_d  = q_model_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    mismatch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          tgt_d      = head[HOLD_W];
          hold_cnt_d = head[HOLD_W-1:0];
          // Excitation table: set only for 0->1, reset only for 1->0.
          // q_model_q cannot be both 0 and 1, so s and r are exclusive.
          s_d        = !q_model_q && head[HOLD_W];
          r_d        = q_model_q && !head[HOLD_W];
          state_d    = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        mismatch  = (q_fb != tgt_q);
        // On a match q_fb equals tgt. On a mismatch the model resyncs to q_fb.
        q_model_d = q_fb;
        state_d   = (hold_cnt_q == HOLD_W'(0)) ? IDLE : HOLD;
      end
      HOLD: begin
        mismatch   = (q_fb != q_model_q);
        q_model_d  = q_fb;
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (mismatch) begin
      err_d     = 1'b1;
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tgt_q      <= 1'b0;
      hold_cnt_q <= '0;
      q_model_q  <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      hold_cnt_q <= hold_cnt_d;
      q_model_q  <= q_model_d;
      s_q        <= s_d;
      r_q        <= r_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
